// File: rtl/cpu_host_sequencer.sv
// cpu_host_sequencer: host-side loader/launcher/readback sequencer for the CPU start/done interface.
// Optional HOST_CYCLE_COUNT_EN: after done, report the run cycle count as a 3-byte response burst.
module cpu_host_sequencer #(
  parameter int IM_SIZE      = 64,
  parameter int DM_SIZE      = 64,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT_W    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [9:0] cmd_addr_i,
  input  logic [8:0] cmd_data_i,
  output logic       im_we_o,
  output logic [9:0] im_waddr_o,
  output logic [8:0] im_wdata_o,
  output logic       dm_we_o,
  output logic [7:0] dm_addr_o,
  output logic [7:0] dm_wdata_o,
  input  logic [7:0] dm_rdata_i,
  output logic       cpu_start_o,
  input  logic       cpu_done_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_last_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic       addr_err_o
);
  localparam logic [10:0]          IM_LIM   = 11'(IM_SIZE);
  localparam logic [8:0]           DM_LIM   = 9'(DM_SIZE);
  localparam logic [7:0]           DM_LAST  = 8'(DM_SIZE - 1);
  localparam logic [15:0]          SC_LAST  = 16'(START_CYCLES - 1);
  // Timeout fires on the step that would bring the counter to all-ones.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {IDLE, WRITE, START, RUN, RB_ADDR, RB_WAIT, RB_SEND} state_e;

  state_e               state_q, state_d;
  logic [9:0]           addr_q, addr_d;
  logic [8:0]           data_q, data_d;
  logic                 is_dm_q, is_dm_d;
  logic                 wr_ok_q, wr_ok_d;
  logic [15:0]          sc_q, sc_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [7:0]           rb_addr_q, rb_addr_d;
  logic [7:0]           remain_q, remain_d;
  logic [7:0]           rsp_byte_q, rsp_byte_d;
  logic                 timeout_q, timeout_d;
  logic                 addr_err_q, addr_err_d;
  logic                 im_ok, dm_ok, rb_state;
  logic [7:0]           rb_next;
`ifdef HOST_CYCLE_COUNT_EN
  logic                 cc_mode_q, cc_mode_d;
  logic [15:0]          cc_hi_q, cc_hi_d;
  logic [23:0]          cnt24;
  assign cnt24 = 24'(cnt_q);
`endif

  assign im_ok    = {1'b0, cmd_addr_i} < IM_LIM;
  assign dm_ok    = {1'b0, cmd_addr_i[7:0]} < DM_LIM;
  assign rb_next  = (rb_addr_q == DM_LAST) ? 8'd0 : rb_addr_q + 8'd1;
  assign rb_state = (state_q == RB_ADDR) || (state_q == RB_WAIT) || (state_q == RB_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      is_dm_q    <= 1'b0;
      wr_ok_q    <= 1'b0;
      sc_q       <= '0;
      cnt_q      <= '0;
      rb_addr_q  <= '0;
      remain_q   <= '0;
      rsp_byte_q <= '0;
      timeout_q  <= 1'b0;
      addr_err_q <= 1'b0;
`ifdef HOST_CYCLE_COUNT_EN
      cc_mode_q  <= 1'b0;
      cc_hi_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      is_dm_q    <= is_dm_d;
      wr_ok_q    <= wr_ok_d;
      sc_q       <= sc_d;
      cnt_q      <= cnt_d;
      rb_addr_q  <= rb_addr_d;
      remain_q   <= remain_d;
      rsp_byte_q <= rsp_byte_d;
      timeout_q  <= timeout_d;
      addr_err_q <= addr_err_d;
`ifdef HOST_CYCLE_COUNT_EN
      cc_mode_q  <= cc_mode_d;
      cc_hi_q    <= cc_hi_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    is_dm_d    = is_dm_q;
    wr_ok_d    = wr_ok_q;
    sc_d       = sc_q;
    cnt_d      = cnt_q;
    rb_addr_d  = rb_addr_q;
    remain_d   = remain_q;
    rsp_byte_d = rsp_byte_q;
    timeout_d  = timeout_q;
    addr_err_d = addr_err_q;
`ifdef HOST_CYCLE_COUNT_EN
    cc_mode_d  = cc_mode_q;
    cc_hi_d    = cc_hi_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (!cmd_op_i[1]) begin
            state_d    = WRITE;
            addr_d     = cmd_addr_i;
            data_d     = cmd_data_i;
            is_dm_d    = cmd_op_i[0];
            wr_ok_d    = cmd_op_i[0] ? dm_ok : im_ok;
            addr_err_d = addr_err_q | (cmd_op_i[0] ? !dm_ok : !im_ok);
          end else if (!cmd_op_i[0]) begin
            state_d   = START;
            sc_d      = '0;
            timeout_d = 1'b0;
          end else begin
            state_d   = RB_ADDR;
            rb_addr_d = cmd_addr_i[7:0];
            remain_d  = cmd_data_i[7:0];
`ifdef HOST_CYCLE_COUNT_EN
            cc_mode_d = 1'b0;
`endif
          end
        end
      end
      WRITE: state_d = IDLE;
      START: begin
        if (sc_q == SC_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          sc_d = sc_q + 16'd1;
        end
      end
      RUN: begin
        if (cpu_done_i) begin
`ifdef HOST_CYCLE_COUNT_EN
          state_d    = RB_SEND;
          rsp_byte_d = cnt24[7:0];
          cc_hi_d    = cnt24[23:8];
          remain_d   = 8'd2;
          cc_mode_d  = 1'b1;
`else
          state_d = IDLE;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      RB_ADDR: state_d = RB_WAIT;
      RB_WAIT: begin
        state_d    = RB_SEND;
        rsp_byte_d = dm_rdata_i;
      end
      RB_SEND: begin
        if (rsp_ready_i) begin
          if (remain_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            remain_d = remain_q - 8'd1;
`ifdef HOST_CYCLE_COUNT_EN
            if (cc_mode_q) begin
              rsp_byte_d = cc_hi_q[7:0];
              cc_hi_d    = {8'd0, cc_hi_q[15:8]};
            end else begin
              state_d   = RB_ADDR;
              rb_addr_d = rb_next;
            end
`else
            state_d   = RB_ADDR;
            rb_addr_d = rb_next;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign im_we_o     = (state_q == WRITE) && !is_dm_q && wr_ok_q;
  assign dm_we_o     = (state_q == WRITE) && is_dm_q && wr_ok_q;
  assign im_waddr_o  = im_we_o ? addr_q : '0;
  assign im_wdata_o  = im_we_o ? data_q : '0;
  assign dm_wdata_o  = dm_we_o ? data_q[7:0] : '0;
  assign dm_addr_o   = ((state_q == WRITE) && is_dm_q) ? addr_q[7:0] : rb_state ? rb_addr_q : '0;
  assign cpu_start_o = state_q == START;
  assign rsp_valid_o = state_q == RB_SEND;
  assign rsp_data_o  = rsp_valid_o ? rsp_byte_q : '0;
  assign rsp_last_o  = rsp_valid_o && (remain_q == 8'd0);
  assign timeout_o   = timeout_q;
  assign addr_err_o  = addr_err_q;
endmodule

// File: doc/cpu_host_sequencer.md
Name: cpu_host_sequencer

Overview:
- Host-side counterpart of the CPU top level's start/done interface.
- Accepts a command stream that loads 9-bit instruction words into instruction memory and bytes into data memory.
- Launches the program by pulsing start, waits for done under a timeout, then streams a window of data memory back to the host.
- Sits beside the CPU core; owns the memory write/read ports while the CPU is not running.

Parameters:
IM_SIZE, 64, instruction memory depth in words (≤1024)
DM_SIZE, 64, data memory depth in bytes (≤256)
START_CYCLES, 2, cycles start is held high per run (≥1)
TIMEOUT_W, 20, width of run-timeout counter

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=WR_IM, 1=WR_DM, 2=RUN, 3=READBACK
cmd_addr  in  10  target address (WR_IM: [9:0]; WR_DM/READBACK: [7:0])
cmd_data  in  9  WR_IM: word; WR_DM: [7:0] byte; READBACK: [7:0]=count-1
im_we  out  1  instruction memory write strobe
im_waddr  out  10  instruction write address
im_wdata  out  9  instruction write word
dm_we  out  1  data memory write strobe
dm_addr  out  8  data memory address (write or read)
dm_wdata  out  8  data memory write byte
dm_rdata  in  8  data memory read data, valid 1 cycle after dm_addr
cpu_start  out  1  CPU start (high = hold/reset PC)
cpu_done  in  1  CPU finished
rsp_valid  out  1  response byte available
rsp_ready  in  1  host consumes response when valid&ready
rsp_data  out  8  response byte
rsp_last  out  1  final byte of a response burst
busy  out  1  high in any state other than IDLE
timeout  out  1  sticky: last RUN hit timeout; cleared on next RUN accept
addr_err  out  1  sticky: out-of-range WR_IM/WR_DM seen; cleared by reset only

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0 except cmd_ready=1 (valid when state is IDLE).
- States: IDLE, WRITE, START, RUN, RB_ADDR, RB_WAIT, RB_SEND.
- cmd_ready=1 only in IDLE; exactly one command per handshake.
- WR_IM accept -> WRITE for 1 cycle: im_we=1, im_waddr=cmd_addr, im_wdata=cmd_data -> IDLE. cmd_addr ≥ IM_SIZE: no strobe, addr_err<=1.
- WR_DM accept -> WRITE: dm_we=1, dm_addr=cmd_addr[7:0], dm_wdata=cmd_data[7:0]. Same range rule vs DM_SIZE. Write latency 1 cycle after accept.
- RUN accept: timeout<=0 -> START: cpu_start=1 for exactly START_CYCLES cycles -> RUN: cpu_start=0, timeout counter counts from 0.
  - cpu_done=1 sampled in RUN -> IDLE.
  - Counter reaches all-ones first -> timeout<=1 -> IDLE.
  - cpu_done is ignored in START.
- READBACK accept: latch base=cmd_addr[7:0], N=cmd_data[7:0]+1 (1..256).
  - RB_ADDR: drive dm_addr -> RB_WAIT (1-cycle read latency) -> RB_SEND: rsp_valid=1, rsp_data=captured byte, rsp_last=1 on the Nth byte.
  - rsp_data/rsp_last are held stable while rsp_valid&!rsp_ready.
  - On handshake: more bytes -> RB_ADDR with next address; else IDLE.
  - Address increments modulo DM_SIZE (DM_SIZE-1 wraps to 0).
- Memory strobes (im_we, dm_we) never asserted in START/RUN; dm_addr is 0 outside WRITE/RB states.
- Reset mid-run or mid-readback: immediate return to IDLE, cpu_start=0, rsp_valid=0, pending burst discarded.

Optional Feature:
HOST_CYCLE_COUNT_EN
- Defined: on done in RUN, emit 3 response bytes with the run cycle count (counter value at done, zero-extended/truncated to 24 bits), LSB first, rsp_last on the third, via the RB_SEND handshake. No bytes on timeout.
- Undefined: RUN produces no response traffic.

Test Plan:
- Reset: rst_n low mid-RUN -> cpu_start=0, busy=0, cmd_ready=1 immediately; stays IDLE after release.
- WR_IM addr=5 data=0x1A3 -> one-cycle im_we with im_waddr=5, im_wdata=0x1A3. WR_IM addr=70 (IM_SIZE=64) -> no im_we, addr_err=1.
- RUN with done raised 10 cycles after start falls -> cpu_start high exactly 2 cycles, busy drops 1 cycle after done, timeout=0. With HOST_CYCLE_COUNT_EN: bytes 0x0A,0x00,0x00, last on third.
- RUN, done never asserted, TIMEOUT_W=4 -> IDLE after 15 RUN cycles, timeout=1; next RUN accept clears it.
- WR_DM 62=0x11, 63=0x22, 0=0x33, then READBACK addr=62 data=2 -> rsp 0x11,0x22,0x33 with rsp_last on 0x33 (wrap).
- rsp_ready held low 5 cycles on the second readback byte -> rsp_data stable, no byte skipped or duplicated.
